cpu_run_ctrl: RTL and testbench

//  Parametrised, synthesizable run controller for single-cycle/pipelined MIPS benches and FPGA bring-up.

---
 rtl/cpu_run_ctrl_pkg.sv | 17 +
 rtl/cpu_run_ctrl_pc_halt_det.sv | 75 +++++++
 rtl/cpu_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding and a
// small saturating-increment helper used by the counters.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } run_state_e;

    // Saturating +1 for a 32-bit value; callers narrow the result.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_pc_halt_det.sv
// Per-core halt detector: watches one PC, counts consecutive repeated
// samples and raises a sticky halted flag once the PC has been seen
// STALL_LIMIT times in a row. The very first enabled sample has no
// predecessor, so it can never count as a repeat.
module pc_halt_det #(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,        // async, active-low
    input  logic            clr_i,        // wipe history (start of a new run)
    input  logic            en_i,         // monitor this cycle
    input  logic [PC_W-1:0] pc_i,
    output logic            halted_o,     // registered sticky flag
    output logic            halted_nxt_o, // flag value after this edge
    output logic            set_o         // flag sets on this edge
);
    import cpu_run_ctrl_pkg::*;

    localparam int SW = $clog2(STALL_LIMIT);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            valid_q, valid_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            halted_q, halted_d;
    logic            set_c;

    // Next-state: history update, saturating stall count, sticky flag.
    always_comb begin
        prev_pc_d = prev_pc_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        halted_d  = halted_q;
        set_c     = 1'b0;
        if (clr_i) begin
            prev_pc_d = '0;
            valid_d   = 1'b0;
            stall_d   = '0;
            halted_d  = 1'b0;
        end else if (en_i) begin
            valid_d   = 1'b1;
            prev_pc_d = pc_i;
            if (valid_q && (pc_i == prev_pc_q)) begin
                stall_d = SW'(sat_inc32(32'(stall_q), 32'(STALL_MAX)));
            end else begin
                stall_d = '0;
            end
            if ((stall_d == STALL_MAX) && !halted_q) begin
                halted_d = 1'b1;
                set_c    = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q <= '0;
            valid_q   <= 1'b0;
            stall_q   <= '0;
            halted_q  <= 1'b0;
        end else begin
            prev_pc_q <= prev_pc_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            halted_q  <= halted_d;
        end
    end

    assign halted_o     = halted_q;
    assign halted_nxt_o = halted_d;
    assign set_o        = set_c;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for MIPS benches / bring-up: holds the cores in reset
// for RST_CYCLES after start, runs them, counts RUN cycles, detects per-core
// halt (PC self-loop) and stops on all-halted or timeout.
// Optional feature macro: CPU_RUN_CTRL_HALT_STAMP_EN adds halt_cycle, the
// cycle_cnt value captured when each core's halted flag set.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int N_CORE      = 1,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 10,
    parameter int STALL_LIMIT = 4,
    parameter int TIMEOUT     = 100000
) (
    input  logic                     clk,
    input  logic                     reset,      // async, active-low
    input  logic                     start,
    input  logic [N_CORE*PC_W-1:0]   core_pc,
    output logic [N_CORE-1:0]        core_rst,
    output logic                     running,
    output logic                     done,
    output logic                     timed_out,
    output logic [N_CORE-1:0]        halted,
    output logic [CNT_W-1:0]         cycle_cnt
`ifdef CPU_RUN_CTRL_HALT_STAMP_EN
    ,
    output logic [N_CORE*CNT_W-1:0]  halt_cycle
`endif
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    run_state_e        state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic              timed_q, timed_d;
    logic [N_CORE-1:0] core_rst_q;
    logic              running_q, done_q;
    logic              enter_hold;
    logic              det_en;
    logic [N_CORE-1:0] det_halted, det_halted_nxt, det_set;
    logic              all_halt_nxt;

    assign det_en       = (state_q == S_RUN);
    assign all_halt_nxt = &det_halted_nxt;

    // One halt detector per monitored core.
    generate
        for (genvar gi = 0; gi < N_CORE; gi++) begin : g_det
            pc_halt_det #(
                .PC_W        (PC_W),
                .STALL_LIMIT (STALL_LIMIT)
            ) u_det (
                .clk          (clk),
                .reset        (reset),
                .clr_i        (enter_hold),
                .en_i         (det_en),
                .pc_i         (core_pc[gi*PC_W +: PC_W]),
                .halted_o     (det_halted[gi]),
                .halted_nxt_o (det_halted_nxt[gi]),
                .set_o        (det_set[gi])
            );
        end
    endgenerate

    // FSM next-state, hold counter, cycle counter and stop reason.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cycle_d    = cycle_q;
        timed_d    = timed_q;
        enter_hold = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_HOLD;
                    hold_d     = '0;
                    cycle_d    = '0;
                    timed_d    = 1'b0;
                    enter_hold = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                // A halt completing this cycle outranks a simultaneous timeout.
                if (all_halt_nxt) begin
                    state_d = S_DONE;
                    timed_d = 1'b0;
                end else if (cycle_q == TO_LAST) begin
                    state_d = S_DONE;
                    timed_d = 1'b1;
                end else if (cycle_q != CNT_MAX) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; outputs derive from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cycle_q    <= '0;
            timed_q    <= 1'b0;
            core_rst_q <= '1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cycle_q    <= cycle_d;
            timed_q    <= timed_d;
            core_rst_q <= {N_CORE{state_d != S_RUN}};
            running_q  <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign core_rst  = core_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timed_out = timed_q;
    assign halted    = det_halted;
    assign cycle_cnt = cycle_q;

`ifdef CPU_RUN_CTRL_HALT_STAMP_EN
    logic [N_CORE*CNT_W-1:0] stamp_q;

    generate
        for (genvar gi = 0; gi < N_CORE; gi++) begin : g_stamp
            // Capture the cycle count once, on the edge the core's flag sets.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stamp_q[gi*CNT_W +: CNT_W] <= '0;
                end else if (enter_hold) begin
                    stamp_q[gi*CNT_W +: CNT_W] <= '0;
                end else if (det_set[gi]) begin
                    stamp_q[gi*CNT_W +: CNT_W] <= cycle_q;
                end
            end
        end
    endgenerate

    assign halt_cycle = stamp_q;
`else
    // Without stamping the set pulses have no consumer.
    logic unused_set;
    assign unused_set = ^det_set;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random PC
// traces, checked against a trace-scanning reference model.
module tb_cpu_run_ctrl;

    localparam int N   = 2;
    localparam int PW  = 32;
    localparam int CW  = 32;
    localparam int RC  = 10;
    localparam int SL  = 4;
    localparam int TO  = 200;
    localparam int BIG = 1000000;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [N*PW-1:0] core_pc = '0;
    logic [N-1:0]    core_rst;
    logic            running, done, timed_out;
    logic [N-1:0]    halted;
    logic [CW-1:0]   cycle_cnt;
`ifdef CPU_RUN_CTRL_HALT_STAMP_EN
    logic [N*CW-1:0] halt_cycle;
`endif

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] seq [N][TO];
    int            h [N];

    cpu_run_ctrl #(
        .N_CORE(N), .PC_W(PW), .CNT_W(CW),
        .RST_CYCLES(RC), .STALL_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .core_pc(core_pc),
        .core_rst(core_rst), .running(running), .done(done),
        .timed_out(timed_out), .halted(halted), .cycle_cnt(cycle_cnt)
`ifdef CPU_RUN_CTRL_HALT_STAMP_EN
        , .halt_cycle(halt_cycle)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rst"},   64'(core_rst), 64'({N{1'b1}}));
        check({tag, "_run"},   64'(running), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_to"},    64'(timed_out), 64'(0));
        check({tag, "_halt"},  64'(halted), 64'(0));
        check({tag, "_cnt"},   64'(cycle_cnt), 64'(0));
    endtask

    // Reference: core i halts at the first RUN cycle k whose sample and the
    // SL-1 preceding samples are all identical. Run ends at the cycle the
    // last core halts, or at TO-1, whichever is first (halt wins a tie).
    task automatic model(output int d, output bit tmo, output logic [N-1:0] hexp);
        int hmax = 0;
        for (int i = 0; i < N; i++) begin
            h[i] = BIG;
            for (int k = SL - 1; k < TO; k++) begin
                bit same = 1'b1;
                for (int j = 1; j < SL; j++)
                    if (seq[i][k-j] != seq[i][k]) same = 1'b0;
                if (same && h[i] == BIG) h[i] = k;
            end
            if (h[i] > hmax) hmax = h[i];
        end
        if (hmax <= TO - 1) begin
            d = hmax; tmo = 1'b0;
        end else begin
            d = TO - 1; tmo = 1'b1;
        end
        for (int i = 0; i < N; i++) hexp[i] = (h[i] <= d);
    endtask

    // Start pulse, HOLD window check, RUN with the trace, DONE readout.
    // abort_at >= 0 drops reset asynchronously in that RUN cycle instead.
    task automatic run_seq(input string name, input int abort_at);
        int d;
        bit tmo;
        logic [N-1:0] hexp;
        model(d, tmo, hexp);
        start = 1'b1;
        tick();
        for (int c = 0; c < RC; c++) begin
            check({name, "_hold_rst"}, 64'(core_rst), 64'({N{1'b1}}));
            check({name, "_hold_run"}, 64'(running), 64'(0));
            check({name, "_hold_halt"}, 64'(halted), 64'(0));
            check({name, "_hold_cnt"}, 64'(cycle_cnt), 64'(0));
            start   = 1'($urandom_range(0, 1));
            core_pc = {$urandom, $urandom};
            tick();
        end
        start = 1'b0;
        for (int k = 0; k <= d; k++) begin
            logic [N-1:0] hrun;
            for (int i = 0; i < N; i++) begin
                core_pc[i*PW +: PW] = seq[i][k];
                hrun[i] = (h[i] < k);
            end
            check({name, "_run"}, 64'(running), 64'(1));
            check({name, "_run_rst"}, 64'(core_rst), 64'(0));
            check({name, "_run_done"}, 64'(done), 64'(0));
            check({name, "_run_cnt"}, 64'(cycle_cnt), 64'(k));
            check({name, "_run_halt"}, 64'(halted), 64'(hrun));
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1 check_idle({name, "_abort"});
                tick();
                tick();
                check_idle({name, "_abort_hold"});
                reset = 1'b1;
                tick();
                check_idle({name, "_abort_idle"});
                $display("run %s aborted at cycle %0d", name, k);
                return;
            end
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            check({name, "_done"}, 64'(done), 64'(1));
            check({name, "_done_run"}, 64'(running), 64'(0));
            check({name, "_done_rst"}, 64'(core_rst), 64'({N{1'b1}}));
            check({name, "_done_cnt"}, 64'(cycle_cnt), 64'(d));
            check({name, "_done_to"}, 64'(timed_out), 64'(tmo));
            check({name, "_done_halt"}, 64'(halted), 64'(hexp));
`ifdef CPU_RUN_CTRL_HALT_STAMP_EN
            for (int i = 0; i < N; i++)
                check({name, "_stamp"}, 64'(halt_cycle[i*CW +: CW]),
                      64'((h[i] <= d) ? h[i] : 0));
`endif
            core_pc = {$urandom, $urandom};
            tick();
        end
        $display("run %s end_cycle=%0d timed_out=%0d halted=%b", name, d, tmo, hexp);
    endtask

    // Core i: fresh PC +4 per cycle, then frozen from cycle freeze on.
    task automatic fill_linear(input int i, input logic [PW-1:0] base, input int freeze);
        for (int k = 0; k < TO; k++)
            seq[i][k] = (k < freeze) ? base + PW'(4 * k) : base + PW'(4 * freeze);
    endtask

    initial begin
        // 1) reset low 3 cycles, then idle with start low
        reset = 1'b0;
        tick(); tick(); tick();
        check_idle("reset");
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_idle("idle");
        end
        $display("step idle done");

        // 2+3) both cores step by 4 for 50 cycles then sit at 0x3030
        for (int i = 0; i < N; i++)
            for (int k = 0; k < TO; k++)
                seq[i][k] = (k < 50) ? PW'(32'h3030 - 4 * (50 - k)) : PW'(32'h3030);
        run_seq("halt53", -1);

        // 4) PC never repeats: timeout
        for (int i = 0; i < N; i++) fill_linear(i, PW'(32'h1000 * (i + 1)), BIG);
        run_seq("timeout", -1);

        // 5) core0 halts at cycle 30, core1 at cycle 80
        fill_linear(0, 32'h0040_0000, 27);
        fill_linear(1, 32'h0080_0000, 77);
        run_seq("twocore", -1);

        // 6) reset in RUN cycle 40, then a clean restart
        for (int i = 0; i < N; i++) fill_linear(i, 32'h0000_2000, BIG);
        run_seq("abort", 40);
        fill_linear(0, 32'h0000_0100, 10);
        fill_linear(1, 32'h0000_0200, 12);
        run_seq("restart", -1);

        // Halt on exactly the timeout cycle: halt wins
        fill_linear(0, 32'h0000_0300, TO - 1 - (SL - 1));
        fill_linear(1, 32'h0000_0400, 5);
        run_seq("tie", -1);

        // Random traces with short stalls and random freeze points
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                int hp = $urandom_range(5, 260);
                seq[i][0] = $urandom & ~32'h3;
                for (int k = 1; k < TO; k++) begin
                    if (k >= hp || $urandom_range(0, 5) == 0) seq[i][k] = seq[i][k-1];
                    else seq[i][k] = seq[i][k-1] + 32'd4;
                end
            end
            run_seq($sformatf("rand%0d", r), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
